// File: rtl/conv_mac_unit.sv
// 3x3 convolution MAC stage: aligns taps to the 1-cycle feature memory, accumulates
// nine pixel*coef products, then shifts/saturates into one output pixel per 12-cycle window.
module conv_mac_unit #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W  = 20,
  parameter int SHIFT  = 4,
  parameter int OUT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               counter0,
  input  logic [1:0]               counter1,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     w_we,
  input  logic [3:0]               w_idx,
  input  logic signed [COEF_W-1:0] w_data,
  output logic [OUT_W-1:0]         wr_data,
  output logic                     wr_en,
  output logic                     sat,
  output logic [15:0]              win_cnt
);
  localparam int PROD_W = DATA_W + COEF_W + 1;

  logic [3:0]               c1x, c0x, cyc_idx;
  logic signed [COEF_W-1:0] coef [9];
  logic [3:0]               tap_d;
  logic                     tap_vld;
  logic signed [ACC_W-1:0]  acc, acc_sh, prod;
  logic signed [PROD_W-1:0] prod_raw;
  logic [OUT_W-1:0]         res;
  logic                     res_sat;

  assign c1x     = {2'b00, counter1};
  assign c0x     = {2'b00, counter0};
  assign cyc_idx = (c1x << 1) + c1x + c0x;

  // Pixels are unsigned; a zero MSB keeps them positive in the signed product.
  assign prod_raw = PROD_W'($signed({1'b0, mem_rdata})) * PROD_W'(coef[tap_d]);
  assign prod     = {{(ACC_W-PROD_W){prod_raw[PROD_W-1]}}, prod_raw};
  assign acc_sh   = acc >>> SHIFT;

  always_comb begin
    res     = acc_sh[OUT_W-1:0];
    res_sat = 1'b0;
    if (acc_sh[ACC_W-1]) begin
      res     = '0;
      res_sat = 1'b1;
    end else if (|acc_sh[ACC_W-2:OUT_W]) begin
      res     = '1;
      res_sat = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) coef[i] <= '0;
      tap_d   <= '0;
      tap_vld <= 1'b0;
      acc     <= '0;
      wr_data <= '0;
      wr_en   <= 1'b0;
      sat     <= 1'b0;
      win_cnt <= '0;
    end else begin
      if (w_we && w_idx <= 4'd8) coef[w_idx] <= w_data;

      // Read data for address ck arrives during c(k+1); tap_d tracks which tap it is.
      if (cyc_idx <= 4'd8) begin
        tap_d   <= cyc_idx;
        tap_vld <= 1'b1;
      end else begin
        tap_vld <= 1'b0;
      end

      // Tap 0 overwrites, so each window starts clean without an explicit clear.
      if (tap_vld) acc <= (tap_d == 4'd0) ? prod : acc + prod;

      wr_en <= 1'b0;
      sat   <= 1'b0;
      if (cyc_idx == 4'd10) begin
        wr_data <= res;
        sat     <= res_sat;
        wr_en   <= 1'b1;
        win_cnt <= win_cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_conv_mac_unit.sv
// Directed bench for conv_mac_unit: emulates the address controller's counters and
// the 1-cycle memory, checks per-window results against hand-computed values.
module tb_conv_mac_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  counter0, counter1;
  logic [7:0]  mem_rdata;
  logic        w_we;
  logic [3:0]  w_idx;
  logic [7:0]  w_data;
  logic [7:0]  wr_data;
  logic        wr_en, sat;
  logic [15:0] win_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  conv_mac_unit dut (
    .clk(clk), .rst(rst), .counter0(counter0), .counter1(counter1),
    .mem_rdata(mem_rdata), .w_we(w_we), .w_idx(w_idx), .w_data(w_data),
    .wr_data(wr_data), .wr_en(wr_en), .sat(sat), .win_cnt(win_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [8:0][7:0] coef;
    logic [8:0][7:0] pix;
    logic [7:0]      exp_data;
    logic            exp_sat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [8:0][7:0] rep(input logic [7:0] x);
    logic [8:0][7:0] r;
    for (int k = 0; k < 9; k++) r[k] = x;
    return r;
  endfunction

  // Idle between windows at c11: no tap capture and no output strobe.
  task automatic park();
    counter1 = 2'd3;
    counter0 = 2'd2;
  endtask

  task automatic load_kernel(input logic [8:0][7:0] k);
    park();
    for (int i = 0; i < 9; i++) begin
      w_we = 1'b1; w_idx = 4'(i); w_data = k[i];
      @(posedge clk); #1;
    end
    w_we = 1'b0;
  endtask

  task automatic run_window(input logic [8:0][7:0] pix, input int ld_cyc,
                            input logic [3:0] ld_idx, input logic [7:0] ld_val,
                            output logic [7:0] o_data, output logic o_sat,
                            output int pulses, output int pcyc, output logic bad_pos);
    pulses = 0; bad_pos = 1'b0; o_data = '0; o_sat = 1'b0; pcyc = -1;
    for (int c = 0; c < 12; c++) begin
      counter1  = 2'(c / 3);
      counter0  = 2'(c % 3);
      mem_rdata = (c >= 1 && c <= 9) ? pix[c-1] : 8'hA5;
      w_we      = (c == ld_cyc);
      w_idx     = ld_idx;
      w_data    = ld_val;
      if (wr_en) begin
        pulses++;
        if (c != 11) bad_pos = 1'b1;
        o_data = wr_data; o_sat = sat; pcyc = cyc;
      end
      @(posedge clk); #1;
    end
    w_we = 1'b0;
    park();
  endtask

  vec_t        v [8];
  logic [7:0]  od;
  logic        os, bp;
  int          np, pc, prev_pc;
  logic [15:0] ewin;

  initial begin
    rst = 1'b1; counter0 = '0; counter1 = '0; mem_rdata = '0;
    w_we = 1'b0; w_idx = '0; w_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_data", wr_data, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_sat", sat, 0);
    chk("rst_win_cnt", win_cnt, 0);
    rst = 1'b0;
    park();
    ewin = 16'd0;

    for (int k = 0; k < 8; k++) begin v[k].coef = '0; v[k].pix = '0; end
    v[0].coef[4] = 8'd16;
    for (int k = 0; k < 9; k++) v[0].pix[k] = 8'(k + 1);
    v[0].exp_data = 8'd5;   v[0].exp_sat = 1'b0;
    v[1].coef = rep(8'd1);   v[1].pix = rep(8'd255); v[1].exp_data = 8'd143; v[1].exp_sat = 1'b0;
    v[2].coef = rep(8'd127); v[2].pix = rep(8'd255); v[2].exp_data = 8'd255; v[2].exp_sat = 1'b1;
    v[3].coef = rep(8'h80);  v[3].pix = rep(8'd255); v[3].exp_data = 8'd0;   v[3].exp_sat = 1'b1;
    for (int k = 0; k < 9; k++) begin
      v[4].coef[k] = 8'(k + 1);
      v[4].pix[k]  = 8'(10 * (k + 1));
    end
    v[4].exp_data = 8'd178; v[4].exp_sat = 1'b0;
    v[5].coef = rep(8'hFF); v[5].pix[4] = 8'd5; v[5].exp_data = 8'd0; v[5].exp_sat = 1'b1;
    v[6].coef[0] = 8'd16; v[6].pix[0] = 8'd255; v[6].exp_data = 8'd255; v[6].exp_sat = 1'b0;
    v[7].coef[0] = 8'd16; v[7].coef[1] = 8'd1; v[7].pix[0] = 8'd255; v[7].pix[1] = 8'd16;
    v[7].exp_data = 8'd255; v[7].exp_sat = 1'b1;

    for (int i = 0; i < 8; i++) begin
      load_kernel(v[i].coef);
      run_window(v[i].pix, -1, 4'd0, 8'd0, od, os, np, pc, bp);
      ewin++;
      chk($sformatf("v%0d_data", i), od, v[i].exp_data);
      chk($sformatf("v%0d_sat", i), os, v[i].exp_sat);
      chk($sformatf("v%0d_pulse", i), {bp, 8'(np)}, 1);
      chk($sformatf("v%0d_win_cnt", i), win_cnt, ewin);
    end

    // Three back-to-back windows: one strobe each, 12 cycles apart.
    load_kernel(rep(8'd1));
    prev_pc = -1;
    for (int w = 0; w < 3; w++) begin
      run_window(rep(8'd255), -1, 4'd0, 8'd0, od, os, np, pc, bp);
      ewin++;
      chk($sformatf("b2b%0d_data", w), od, 143);
      if (w > 0) chk($sformatf("b2b%0d_spacing", w), pc - prev_pc, 12);
      prev_pc = pc;
    end
    chk("b2b_win_cnt", win_cnt, ewin);

    // Mid-window coefficient loads.
    load_kernel(rep(8'd16));
    run_window(rep(8'd10), 3, 4'd12, 8'd0, od, os, np, pc, bp); ewin++;
    chk("mid_idx12_data", od, 90);
    chk("mid_idx12_pulse", {bp, 8'(np)}, 1);
    run_window(rep(8'd10), 3, 4'd8, 8'd0, od, os, np, pc, bp); ewin++;
    chk("mid_c8_data", od, 80);
    chk("mid_c8_pulse", {bp, 8'(np)}, 1);
    run_window(rep(8'd10), 5, 4'd0, 8'd0, od, os, np, pc, bp); ewin++;
    chk("mid_late_c0_data", od, 80);
    chk("mid_late_c0_pulse", {bp, 8'(np)}, 1);
    run_window(rep(8'd10), -1, 4'd0, 8'd0, od, os, np, pc, bp); ewin++;
    chk("mid_after_data", od, 70);
    chk("mid_after_win_cnt", win_cnt, ewin);

    // Reset arriving at c5 with a partial sum in flight.
    for (int c = 0; c < 5; c++) begin
      counter1 = 2'(c / 3); counter0 = 2'(c % 3);
      mem_rdata = 8'd200;
      @(posedge clk); #1;
    end
    counter1 = 2'd1; counter0 = 2'd2; rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_wr_data", wr_data, 0);
    chk("midrst_wr_en", wr_en, 0);
    chk("midrst_sat", sat, 0);
    chk("midrst_win_cnt", win_cnt, 0);
    counter1 = 2'd0; counter0 = 2'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    ewin = 16'd0;
    run_window(rep(8'd0), -1, 4'd0, 8'd0, od, os, np, pc, bp); ewin++;
    chk("postrst_data", od, 0);
    chk("postrst_pulse", {bp, 8'(np)}, 1);
    chk("postrst_win_cnt", win_cnt, 1);
    run_window(rep(8'd255), -1, 4'd0, 8'd0, od, os, np, pc, bp); ewin++;
    chk("postrst_coef_cleared", od, 0);
    chk("postrst_coef_sat", os, 0);

    // Window counter wrap, preloaded near the top.
    park();
    force dut.win_cnt = 16'hFFFE;
    @(posedge clk); #1;
    release dut.win_cnt;
    chk("wrap_preload", win_cnt, 16'hFFFE);
    ewin = 16'hFFFE;
    for (int w = 0; w < 3; w++) begin
      run_window(rep(8'd0), -1, 4'd0, 8'd0, od, os, np, pc, bp);
      ewin++;
      chk($sformatf("wrap%0d_win_cnt", w), win_cnt, ewin);
      chk($sformatf("wrap%0d_pulse", w), {bp, 8'(np)}, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/conv_mac_unit.md
# conv_mac_unit

Convolution datapath stage directly downstream of the 3x3 convolution address controller. It consumes the controller's phase counters and the pixel stream returned by the 1-cycle-latency feature memory, and multiply-accumulates the nine window pixels against a loadable 3x3 kernel. It then right-shifts and saturates the sum and presents one output pixel, with a write strobe, in the final cycle of each 12-cycle window, timed so that it lands on the controller's write address.

## Interface
- DATA_W, 8, unsigned pixel width (mem_rdata)
- COEF_W, 8, signed kernel coefficient width
- ACC_W, 20, signed accumulator width; must hold 9 * (2^DATA_W - 1) * 2^(COEF_W-1)
- SHIFT, 4, arithmetic right shift applied to the accumulator before saturation
- OUT_W, 8, unsigned output pixel width
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- counter0  in  2  controller column phase (0..2)
- counter1  in  2  controller row phase (0..3; 3 = write phase)
- mem_rdata  in  DATA_W  pixel read data, valid one cycle after its address
- w_we  in  1  kernel coefficient write strobe
- w_idx  in  4  coefficient index, 0..8, row-major (idx = row*3 + col)
- w_data  in  COEF_W  signed coefficient
- wr_data  out  OUT_W  result pixel
- wr_en  out  1  one-cycle strobe; wr_data is valid while it is high
- sat  out  1  high with wr_en when the result was clamped
- win_cnt  out  16  count of completed windows, wraps modulo 2^16

## Operation
- Window cycle index: c = counter1*3 + counter0, range 0..11.
  - c0..c8 are read cycles; tap k = c.
  - c9..c11 are write phase, where the controller's rw = 1.
- Tap alignment stage:
  - At the edge ending c0..c8: tap_d <= c, tap_vld <= 1.
  - At the edge ending any of c9..c11: tap_vld <= 0.
- Accumulate stage, on each edge where tap_vld = 1:
  - prod = $signed({1'b0, mem_rdata}) * coef[tap_d], sign-extended to ACC_W.
  - acc <= (tap_d == 0) ? prod : acc + prod. Tap 0 restarts the accumulator, so there is no separate clear.
  - No overflow is possible when ACC_W meets its parameter rule; the bench checks defaults only.
- Output stage, at the edge ending c10:
  - r = acc >>> SHIFT (arithmetic).
  - If r < 0: wr_data <= 0, sat <= 1.
  - Else if r > 2^OUT_W - 1: wr_data <= 2^OUT_W - 1, sat <= 1.
  - Otherwise: wr_data <= r[OUT_W-1:0], sat <= 0.
  - Also at this edge: wr_en <= 1, win_cnt <= win_cnt + 1.
- At every other edge, wr_en <= 0 and sat <= 0. wr_data holds its last value.
- Kernel register file (coef[0..8]):
  - w_we = 1 with w_idx <= 8: coef[w_idx] <= w_data at that edge. The new value is used by products from the next edge onward.
  - w_we = 1 with w_idx >= 9: ignored.
  - A load during an active window is legal. Taps already accumulated keep their old coefficient; later taps use the new one.
- Outputs during the first window after reset are garbage-free: tap_vld and wr_en are 0 until the controller emits c0 and c9/c10 respectively.

## Timing
- Reset (synchronous, takes priority over every other action) clears:
  - wr_data = 0, wr_en = 0, sat = 0, win_cnt = 0
  - acc = 0, tap_d = 0, tap_vld = 0
  - all coef = 0
- Reset mid-window abandons the partial sum. The controller resets on the same rst, so the next c0 starts a clean window.
- Pixel k address is issued at ck, and the data is accumulated at the edge ending c(k+1). The final tap is in acc during c10.
- Latency: wr_en is high exactly during c11, one cycle per window, coinciding with the controller's last write-phase cycle. Memory captures wr_data at the end of c11.
- Window period is 12 cycles, with no stalls. The block has no back-pressure and assumes the counters advance every cycle.
- mem_rdata is sampled only on edges where tap_vld = 1. During the write phase it is don't-care.
- win_cnt wraps from 0xFFFF to 0x0000 without any flag.

## Test plan
- Identity kernel: coef[4] = 16, others 0, SHIFT = 4, pixels 1..9 across the window -> wr_en only in c11, wr_data = 5, sat = 0, win_cnt = 1.
- All ones: all coef = 1, all pixels 255 -> acc = 2295, 2295 >>> 4 = 143 -> wr_data = 143, sat = 0. Three back-to-back windows -> win_cnt = 3, wr_en pulses spaced 12 cycles apart.
- Saturation high and low:
  - all coef = 127, pixels 255 -> wr_data = 255, sat = 1.
  - all coef = -128, pixels 255 -> wr_data = 0, sat = 1.
- Mid-window load: all coef = 16, pixels all 10; write coef[8] = 0 during c3 -> acc = 8*160 = 1280 -> wr_data = 80. Write w_idx = 12 -> no coefficient change.
- Reset at c5 with nonzero acc, then a full window of all-zero pixels -> all outputs 0 during reset, next wr_data = 0, win_cnt = 1.
- Wrap: force 65536 windows (or preload via a backdoor) -> win_cnt returns to 0 and wr_en still pulses each window.
